ifmap_window_addr_gen: RTL and testbench
========================================

# ifmap_window_addr_gen

Parametrised input-feature-map read-address generator for the convolution datapath. It sits between the layer controller and the ifmap buffer. For each configured row it walks every filter window at a programmable stride and emits one buffer read address per filter tap on a valid/ready stream. Beyond the single-row head/offset generator it adds:
- multi-row sequencing;
- runtime filter size and stride;
- modulo-2^ADDR_W buffer wrap;
- backpressure;
- configuration checking.

## Interface
- ADDR_W, 8, buffer address width; the buffer depth is 2^ADDR_W.
- LEN_W, 8, width of the row-length field.
- ROWS_W, 6, width of the row-count field.
- FILT_W, 3, width of the filter-size field.
- STRIDE_W, 2, width of the stride field.
- clk  in  1  single clock. Reset is synchronous and active-high, named rst.
- rst  in  1  synchronous active-high reset.
- start  in  1  job request; sampled only in IDLE.
- cfg_base  in  ADDR_W  buffer address of element 0 of row 0.
- cfg_row_len  in  LEN_W  elements per row.
- cfg_rows  in  ROWS_W  number of rows.
- cfg_filt  in  FILT_W  filter taps per window.
- cfg_stride  in  STRIDE_W  head advance between windows.
- busy  out  1  high in LOAD and RUN.
- addr_valid  out  1  raddr is valid.
- addr_ready  in  1  consumer accepts raddr.
- raddr  out  ADDR_W  read address.
- win_first  out  1  qualifies tap 0 of a window.
- win_last  out  1  qualifies the last tap of a window.
- row_last  out  1  qualifies the last tap of the last window in a row.
- done  out  1  one-cycle pulse at job end.
- cfg_err  out  1  one-cycle pulse, concurrent with done, on a rejected config.

## Operation
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE -> LOAD on start. LOAD latches all cfg_* inputs into shadow registers.
- LOAD -> FIN with cfg_err when any of these holds: filt==0, stride==0, rows==0, or filt>row_len. No addresses are emitted in that case.
- LOAD -> RUN otherwise. On entry: row=0, head=0, off=0, row_base=cfg_base.
- RUN: raddr = row_base + head + off, truncated to ADDR_W. Wrap past 2^ADDR_W-1 to 0 is required.
- A transfer occurs on addr_valid && addr_ready. Each transfer advances the counters as follows:
  - off < filt-1: off++.
  - Otherwise off=0. Then, if head+stride+filt <= row_len: head += stride.
  - Otherwise head=0, row++, row_base += row_len (mod 2^ADDR_W).
- Trailing elements that cannot fit a full window are skipped.
- Windows per row = floor((row_len-filt)/stride)+1.
- After the transfer of the final tap of row rows-1, RUN -> FIN.
- FIN: done=1 for one cycle, then -> IDLE.
- start outside IDLE is ignored. Inputs cfg_* are don't-care outside LOAD.
- Internal arithmetic: head/off sums are held in LEN_W+1 bits for the window-fit compare. The address sum is truncated to ADDR_W.

## Timing
- Reset (synchronous, any state, including mid-job) forces:
  - state=IDLE;
  - busy, addr_valid, win_first, win_last, row_last, done, cfg_err, raddr all 0;
  - counters 0.
- Latency: start at edge N -> LOAD in cycle N+1 -> first addr_valid in cycle N+2.
- Throughput: one address per cycle while addr_ready=1.
- With addr_valid=1 and addr_ready=0, raddr and all qualifiers hold stable. addr_valid never drops without a transfer.
- All outputs are registered. Qualifiers are aligned with their raddr.
- done follows the final transfer by exactly one cycle. start in that FIN cycle is ignored.
- The next job is accepted in the first IDLE cycle.
- Error path: start -> LOAD -> FIN, so done and cfg_err pulse 2 cycles after start.

## Structure
- Package ifmap_pkg holds:
  - the state enum (IDLE/LOAD/RUN/FIN);
  - the default width constants;
  - the cfg struct (base, row_len, rows, filt, stride) used by the shadow register.
- One sub-module, win_step_counter: the off/head/row nested counter with its wrap and fit compare. It exposes tap/window/row last flags. The top level keeps the FSM, the shadow register, the address adder and the output registers.

## Test plan
- Basic sliding: base=0, row_len=6, filt=3, stride=1, rows=1, ready=1 -> raddr 0,1,2,1,2,3,2,3,4,3,4,5. win_last on every 3rd address; row_last on the 12th; done 1 cycle later.
- Stride with leftover, multi-row: row_len=7, filt=3, stride=2, rows=2, base=10:
  - Row 0 heads 0,2,4 -> 10..12, 12..14, 14..16.
  - Row 1 -> 17..19, 19..21, 21..23.
  - 18 transfers total.
- Wrap: ADDR_W=4, base=14, row_len=4, filt=2, stride=2, rows=1 -> raddr 14,15,0,1.
- Backpressure: run the basic case with addr_ready toggling in a random pattern -> raddr sequence is identical; values hold stable while stalled; no drops or duplicates.
- Config error: filt=5, row_len=4 -> no addr_valid; done and cfg_err pulse together 2 cycles after start. Repeat with stride=0 -> same response.
- Reset/start abuse:
  - start pulsed during RUN -> ignored.
  - rst asserted mid-row -> the next cycle shows all outputs 0 and IDLE.
  - A fresh start then produces a complete, correct sequence.

Source files
------------

// File: rtl/ifmap_window_addr_gen_pkg.sv
// Shared types and constants for the ifmap window read-address generator.
package ifmap_pkg;

    // Default field widths. The configuration shadow register is sized by
    // these, so no instance may use wider fields than the defaults.
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_LEN_W    = 8;
    localparam int DEF_ROWS_W   = 6;
    localparam int DEF_FILT_W   = 3;
    localparam int DEF_STRIDE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]   base;
        logic [DEF_LEN_W-1:0]    row_len;
        logic [DEF_ROWS_W-1:0]   rows;
        logic [DEF_FILT_W-1:0]   filt;
        logic [DEF_STRIDE_W-1:0] stride;
    } cfg_t;

    // A job is rejected when it could never emit a complete window.
    function automatic logic cfg_rejected(input cfg_t c);
        logic bad;
        bad = (c.filt == '0) || (c.stride == '0) || (c.rows == '0) ||
              ((DEF_LEN_W+1)'(c.filt) > (DEF_LEN_W+1)'(c.row_len));
        return bad;
    endfunction

endpackage

// File: rtl/ifmap_window_addr_gen_if.sv
// Read-address stream from the generator to the ifmap buffer.
interface ifmap_window_addr_gen_if #(
    parameter int ADDR_W = 8
) ();
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] raddr;
    logic              win_first;
    logic              win_last;
    logic              row_last;

    modport master (
        output addr_valid, raddr, win_first, win_last, row_last,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, raddr, win_first, win_last, row_last,
        output addr_ready
    );
endinterface

// File: rtl/ifmap_window_addr_gen_win_step_counter.sv
// Nested tap-offset / window-head / row counter. The counters describe the
// next tap to be issued; step advances them by one tap.
module win_step_counter #(
    parameter int LEN_W    = 8,
    parameter int ROWS_W   = 6,
    parameter int FILT_W   = 3,
    parameter int STRIDE_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                step,
    input  logic [LEN_W-1:0]    row_len,
    input  logic [ROWS_W-1:0]   rows,
    input  logic [FILT_W-1:0]   filt,
    input  logic [STRIDE_W-1:0] stride,
    output logic [FILT_W-1:0]   off,
    output logic [LEN_W-1:0]    head,
    output logic                tap_first,
    output logic                tap_last,
    output logic                row_end,
    output logic                job_end
);

    logic [FILT_W-1:0] off_r;
    logic [LEN_W-1:0]  head_r;
    logic [ROWS_W-1:0] row_r;
    logic [LEN_W:0]    fit_sum_s;
    logic              fits_s;
    logic              tap_last_s;

    // Window-fit compare and last-tap/row/job flags for the current tap.
    always_comb begin
        fit_sum_s  = (LEN_W+1)'(head_r) + (LEN_W+1)'(stride) + (LEN_W+1)'(filt);
        fits_s     = (fit_sum_s <= (LEN_W+1)'(row_len));
        tap_last_s = (off_r == (filt - FILT_W'(1)));
    end

    assign off       = off_r;
    assign head      = head_r;
    assign tap_first = (off_r == '0);
    assign tap_last  = tap_last_s;
    assign row_end   = tap_last_s && !fits_s;
    assign job_end   = tap_last_s && !fits_s && (row_r == (rows - ROWS_W'(1)));

    // Advance off, then head by stride, then row; trailing elements that
    // cannot hold a full window are skipped by the fit compare.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            off_r  <= '0;
            head_r <= '0;
            row_r  <= '0;
        end else if (step) begin
            if (!tap_last_s) begin
                off_r <= off_r + FILT_W'(1);
            end else begin
                off_r <= '0;
                if (fits_s) begin
                    head_r <= head_r + LEN_W'(stride);
                end else begin
                    head_r <= '0;
                    row_r  <= row_r + ROWS_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ifmap_window_addr_gen.sv
// Ifmap buffer read-address generator: walks every filter window of every
// configured row and streams one address per tap.
module ifmap_window_addr_gen
    import ifmap_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int ROWS_W   = DEF_ROWS_W,
    parameter int FILT_W   = DEF_FILT_W,
    parameter int STRIDE_W = DEF_STRIDE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [LEN_W-1:0]    cfg_row_len,
    input  logic [ROWS_W-1:0]   cfg_rows,
    input  logic [FILT_W-1:0]   cfg_filt,
    input  logic [STRIDE_W-1:0] cfg_stride,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    ifmap_window_addr_gen_if.master rd
);

    state_t            state_r;
    cfg_t              cfg_r;
    cfg_t              live_cfg_s;
    cfg_t              src_cfg_s;
    logic              cfg_bad_s;
    logic              load_s;
    logic              clear_s;

    logic              valid_r;
    logic              busy_r;
    logic              done_r;
    logic              cfg_err_r;
    logic [ADDR_W-1:0] raddr_r;
    logic              win_first_r;
    logic              win_last_r;
    logic              row_last_r;
    logic              job_last_r;
    logic [ADDR_W-1:0] row_base_r;

    logic [ADDR_W-1:0]   base_src_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [ADDR_W-1:0]   row_base_nxt_s;
    logic [LEN_W-1:0]    row_len_src_s;
    logic [ROWS_W-1:0]   rows_src_s;
    logic [FILT_W-1:0]   filt_src_s;
    logic [STRIDE_W-1:0] stride_src_s;

    logic [FILT_W-1:0] off_s;
    logic [LEN_W-1:0]  head_s;
    logic              tap_first_s;
    logic              tap_last_s;
    logic              row_end_s;
    logic              job_end_s;

    // Pack the live configuration inputs into the shadow-register layout.
    always_comb begin
        live_cfg_s         = '0;
        live_cfg_s.base    = DEF_ADDR_W'(cfg_base);
        live_cfg_s.row_len = DEF_LEN_W'(cfg_row_len);
        live_cfg_s.rows    = DEF_ROWS_W'(cfg_rows);
        live_cfg_s.filt    = DEF_FILT_W'(cfg_filt);
        live_cfg_s.stride  = DEF_STRIDE_W'(cfg_stride);
    end

    assign cfg_bad_s = cfg_rejected(live_cfg_s);

    // The first tap is issued from LOAD, before the shadow register holds the
    // job, so LOAD reads the live inputs and every later cycle the shadow.
    always_comb begin
        if (state_r == LOAD) begin
            src_cfg_s  = live_cfg_s;
            base_src_s = cfg_base;
        end else begin
            src_cfg_s  = cfg_r;
            base_src_s = row_base_r;
        end
    end

    assign row_len_src_s = LEN_W'(src_cfg_s.row_len);
    assign rows_src_s    = ROWS_W'(src_cfg_s.rows);
    assign filt_src_s    = FILT_W'(src_cfg_s.filt);
    assign stride_src_s  = STRIDE_W'(src_cfg_s.stride);

    // Decide when the output register takes the next tap.
    always_comb begin
        load_s  = 1'b0;
        clear_s = 1'b0;
        case (state_r)
            IDLE:    clear_s = 1'b1;
            LOAD:    load_s  = !cfg_bad_s;
            RUN:     load_s  = rd.addr_ready && !job_last_r;
            FIN:     clear_s = 1'b1;
            default: clear_s = 1'b1;
        endcase
    end

    win_step_counter #(
        .LEN_W    (LEN_W),
        .ROWS_W   (ROWS_W),
        .FILT_W   (FILT_W),
        .STRIDE_W (STRIDE_W)
    ) u_step (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .step      (load_s),
        .row_len   (row_len_src_s),
        .rows      (rows_src_s),
        .filt      (filt_src_s),
        .stride    (stride_src_s),
        .off       (off_s),
        .head      (head_s),
        .tap_first (tap_first_s),
        .tap_last  (tap_last_s),
        .row_end   (row_end_s),
        .job_end   (job_end_s)
    );

    // Address sum wraps modulo the buffer depth; row base moves by row_len.
    always_comb begin
        addr_s = base_src_s + ADDR_W'(head_s) + ADDR_W'(off_s);
        if (row_end_s) begin
            row_base_nxt_s = base_src_s + ADDR_W'(row_len_src_s);
        end else begin
            row_base_nxt_s = base_src_s;
        end
    end

    // Job sequencing, shadow capture and the handshake/status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cfg_r     <= '0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r    <= 1'b0;
                    cfg_err_r <= 1'b0;
                    if (start) begin
                        state_r <= LOAD;
                        busy_r  <= 1'b1;
                    end
                end
                LOAD: begin
                    cfg_r <= live_cfg_s;
                    if (cfg_bad_s) begin
                        state_r   <= FIN;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        cfg_err_r <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        valid_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (rd.addr_ready && job_last_r) begin
                        state_r <= FIN;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                FIN: begin
                    state_r   <= IDLE;
                    done_r    <= 1'b0;
                    cfg_err_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    valid_r   <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    cfg_err_r <= 1'b0;
                end
            endcase
        end
    end

    // Output address/qualifier register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_r     <= '0;
            win_first_r <= 1'b0;
            win_last_r  <= 1'b0;
            row_last_r  <= 1'b0;
            job_last_r  <= 1'b0;
            row_base_r  <= '0;
        end else if (load_s) begin
            raddr_r     <= addr_s;
            win_first_r <= tap_first_s;
            win_last_r  <= tap_last_s;
            row_last_r  <= row_end_s;
            job_last_r  <= job_end_s;
            row_base_r  <= row_base_nxt_s;
        end
    end

    assign rd.addr_valid = valid_r;
    assign rd.raddr      = raddr_r;
    assign rd.win_first  = win_first_r;
    assign rd.win_last   = win_last_r;
    assign rd.row_last   = row_last_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign cfg_err       = cfg_err_r;

endmodule

// File: tb/tb_ifmap_window_addr_gen.sv
// Directed bench for ifmap_window_addr_gen: an 8-bit-address instance for
// most jobs and a 4-bit-address instance for the wrap case.
module tb_ifmap_window_addr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] base8;
    logic [3:0] base4;
    logic [7:0] row_len;
    logic [5:0] rows;
    logic [2:0] filt;
    logic [1:0] stride;
    logic       busy8, done8, err8, busy4, done4, err4;

    ifmap_window_addr_gen_if #(.ADDR_W(8)) rd8 ();
    ifmap_window_addr_gen_if #(.ADDR_W(4)) rd4 ();

    ifmap_window_addr_gen #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .cfg_base(base8),
        .cfg_row_len(row_len), .cfg_rows(rows), .cfg_filt(filt),
        .cfg_stride(stride), .busy(busy8), .done(done8), .cfg_err(err8),
        .rd(rd8)
    );

    ifmap_window_addr_gen #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .cfg_base(base4),
        .cfg_row_len(row_len), .cfg_rows(rows), .cfg_filt(filt),
        .cfg_stride(stride), .busy(busy4), .done(done4), .cfg_err(err4),
        .rd(rd4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the most recent job capture.
    logic [7:0] q_addr[$];
    bit         q_wf[$], q_wl[$], q_rl[$];
    int         n_done, done_cyc, n_err, err_cyc, last_xfer, first_v;
    int         hold_bad, n_valid, post_busy;
    logic       load_valid, load_busy;

    // Present a configuration and pulse start; sample the LOAD cycle.
    task automatic go(input bit sel, input logic [7:0] b, input logic [7:0] rl,
                      input logic [5:0] r, input logic [2:0] f, input logic [1:0] s);
        @(negedge clk);
        base8 = b; base4 = b[3:0]; row_len = rl; rows = r; filt = f; stride = s;
        if (sel) start4 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start4 = 1'b0;
        load_valid = sel ? rd4.addr_valid : rd8.addr_valid;
        load_busy  = sel ? busy4 : busy8;
    endtask

    // Record transfers and status until done (+post cycles), bounded.
    task automatic capture(input bit sel, input bit bp, input int start_cyc,
                           input int rst_cyc, input int post);
        logic       v, wf, wl, rl, bz, dn, er, rdy;
        logic [7:0] a, pa;
        bit         stall, pwf, pwl, prl;
        q_addr.delete(); q_wf.delete(); q_wl.delete(); q_rl.delete();
        n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1; last_xfer = -1;
        first_v = -1; hold_bad = 0; n_valid = 0; post_busy = 0;
        stall = 1'b0; pa = 8'd0; pwf = 1'b0; pwl = 1'b0; prl = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (sel) begin
                v = rd4.addr_valid; a = {4'd0, rd4.raddr}; wf = rd4.win_first;
                wl = rd4.win_last; rl = rd4.row_last; bz = busy4; dn = done4; er = err4;
                start4 = (cyc == start_cyc);
            end else begin
                v = rd8.addr_valid; a = rd8.raddr; wf = rd8.win_first;
                wl = rd8.win_last; rl = rd8.row_last; bz = busy8; dn = done8; er = err8;
                start8 = (cyc == start_cyc);
            end
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                return;
            end
            if (stall && (!v || a !== pa || wf !== pwf || wl !== pwl || rl !== prl))
                hold_bad++;
            if (v) begin
                n_valid++;
                if (first_v < 0) first_v = cyc;
            end
            if (dn) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (er) begin
                n_err++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (done_cyc >= 0 && (bz || v)) post_busy++;
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            rd8.addr_ready = rdy;
            rd4.addr_ready = rdy;
            if (v && rdy) begin
                q_addr.push_back(a); q_wf.push_back(wf);
                q_wl.push_back(wl);  q_rl.push_back(rl);
                last_xfer = cyc;
            end
            stall = v && !rdy;
            pa = a; pwf = wf; pwl = wl; prl = rl;
            if (done_cyc >= 0 && cyc >= done_cyc + post) break;
        end
        start8 = 1'b0; start4 = 1'b0;
        rd8.addr_ready = 1'b1; rd4.addr_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [14:0] obs8;
        logic [10:0] obs4;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs8 = {busy8, rd8.addr_valid, rd8.raddr, rd8.win_first, rd8.win_last,
                rd8.row_last, done8, err8};
        obs4 = {busy4, rd4.addr_valid, rd4.raddr, rd4.win_first, rd4.win_last,
                rd4.row_last, done4, err4};
        n_cmp++;
        if (obs8 !== 15'd0) begin
            n_bad++; $display("FAIL reset8 outputs got %h want 0", obs8);
        end
        n_cmp++;
        if (obs4 !== 11'd0) begin
            n_bad++; $display("FAIL reset4 outputs got %h want 0", obs4);
        end
        rst = 1'b0;
    endtask

    // Basic sliding job: expect 0,1,2,1,2,3,2,3,4,3,4,5. Used by several tests.
    task automatic check_basic_seq(input string tag);
        logic [7:0]  ea[12] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3,
                                8'd2, 8'd3, 8'd4, 8'd3, 8'd4, 8'd5};
        logic [11:0] wf_e = 12'h249;
        logic [11:0] wl_e = 12'h924;
        logic [11:0] rl_e = 12'h800;
        n_cmp++;
        if (q_addr.size() != 12) begin
            n_bad++; $display("FAIL %s_count got %0d want 12", tag, q_addr.size());
        end
        for (int i = 0; i < 12 && i < q_addr.size(); i++) begin
            n_cmp++;
            if (q_addr[i] !== ea[i] || q_wf[i] !== wf_e[i] || q_wl[i] !== wl_e[i] ||
                q_rl[i] !== rl_e[i]) begin
                n_bad++;
                $display("FAIL %s_tap%0d got addr=%0d f/l/r=%b%b%b want addr=%0d f/l/r=%b%b%b",
                         tag, i, q_addr[i], q_wf[i], q_wl[i], q_rl[i],
                         ea[i], wf_e[i], wl_e[i], rl_e[i]);
            end
        end
        n_cmp++;
        if (n_done != 1 || done_cyc != last_xfer + 1 || n_err != 0) begin
            n_bad++;
            $display("FAIL %s_done got n=%0d cyc=%0d err=%0d want n=1 cyc=%0d err=0",
                     tag, n_done, done_cyc, n_err, last_xfer + 1);
        end
    endtask

    task automatic test_basic();
        go(1'b0, 8'd0, 8'd6, 6'd1, 3'd3, 2'd1);
        n_cmp++;
        if (load_valid !== 1'b0 || load_busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_load got valid=%b busy=%b want 0 1", load_valid, load_busy);
        end
        capture(1'b0, 1'b0, -1, -1, 2);
        n_cmp++;
        if (first_v != 0) begin
            n_bad++; $display("FAIL basic_latency got first valid cyc %0d want 0", first_v);
        end
        check_basic_seq("basic");
        n_cmp++;
        if (post_busy != 0) begin
            n_bad++; $display("FAIL basic_idle got %0d busy cycles after done want 0", post_busy);
        end
    endtask

    task automatic test_backpressure();
        go(1'b0, 8'd0, 8'd6, 6'd1, 3'd3, 2'd1);
        capture(1'b0, 1'b1, -1, -1, 2);
        check_basic_seq("bp");
        n_cmp++;
        if (hold_bad != 0) begin
            n_bad++; $display("FAIL bp_hold got %0d unstable stalls want 0", hold_bad);
        end
    endtask

    // Back-to-back: start in the first IDLE cycle after the basic job.
    task automatic test_multi_back_to_back();
        logic [7:0]  ea[18] = '{8'd10, 8'd11, 8'd12, 8'd12, 8'd13, 8'd14,
                                8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19,
                                8'd19, 8'd20, 8'd21, 8'd21, 8'd22, 8'd23};
        logic [17:0] wf_e = 18'h09249;
        logic [17:0] wl_e = 18'h24924;
        logic [17:0] rl_e = 18'h20100;
        go(1'b0, 8'd0, 8'd6, 6'd1, 3'd3, 2'd1);
        capture(1'b0, 1'b0, -1, -1, 0);
        go(1'b0, 8'd10, 8'd7, 6'd2, 3'd3, 2'd2);
        n_cmp++;
        if (load_busy !== 1'b1) begin
            n_bad++; $display("FAIL b2b_accept got busy=%b want 1", load_busy);
        end
        capture(1'b0, 1'b0, -1, -1, 2);
        n_cmp++;
        if (q_addr.size() != 18) begin
            n_bad++; $display("FAIL multi_count got %0d want 18", q_addr.size());
        end
        for (int i = 0; i < 18 && i < q_addr.size(); i++) begin
            n_cmp++;
            if (q_addr[i] !== ea[i] || q_wf[i] !== wf_e[i] || q_wl[i] !== wl_e[i] ||
                q_rl[i] !== rl_e[i]) begin
                n_bad++;
                $display("FAIL multi_tap%0d got addr=%0d f/l/r=%b%b%b want addr=%0d f/l/r=%b%b%b",
                         i, q_addr[i], q_wf[i], q_wl[i], q_rl[i],
                         ea[i], wf_e[i], wl_e[i], rl_e[i]);
            end
        end
        n_cmp++;
        if (n_done != 1 || done_cyc != last_xfer + 1) begin
            n_bad++; $display("FAIL multi_done got n=%0d cyc=%0d want n=1 cyc=%0d",
                              n_done, done_cyc, last_xfer + 1);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ea[4] = '{8'd14, 8'd15, 8'd0, 8'd1};
        logic [3:0] wf_e = 4'b0101;
        logic [3:0] wl_e = 4'b1010;
        logic [3:0] rl_e = 4'b1000;
        go(1'b1, 8'd14, 8'd4, 6'd1, 3'd2, 2'd2);
        capture(1'b1, 1'b0, -1, -1, 2);
        n_cmp++;
        if (q_addr.size() != 4) begin
            n_bad++; $display("FAIL wrap_count got %0d want 4", q_addr.size());
        end
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            n_cmp++;
            if (q_addr[i] !== ea[i] || q_wf[i] !== wf_e[i] || q_wl[i] !== wl_e[i] ||
                q_rl[i] !== rl_e[i]) begin
                n_bad++;
                $display("FAIL wrap_tap%0d got addr=%0d f/l/r=%b%b%b want addr=%0d f/l/r=%b%b%b",
                         i, q_addr[i], q_wf[i], q_wl[i], q_rl[i],
                         ea[i], wf_e[i], wl_e[i], rl_e[i]);
            end
        end
        n_cmp++;
        if (n_done != 1 || done_cyc != last_xfer + 1) begin
            n_bad++; $display("FAIL wrap_done got n=%0d cyc=%0d want n=1 cyc=%0d",
                              n_done, done_cyc, last_xfer + 1);
        end
    endtask

    // Two rejected configs: filt > row_len, then stride == 0.
    task automatic test_cfg_err();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) go(1'b0, 8'd0, 8'd4, 6'd1, 3'd5, 2'd1);
            else        go(1'b0, 8'd0, 8'd4, 6'd1, 3'd2, 2'd0);
            capture(1'b0, 1'b0, -1, -1, 2);
            n_cmp++;
            if (load_valid !== 1'b0 || n_valid != 0) begin
                n_bad++; $display("FAIL err%0d_novalid got %0d valid cycles want 0", k, n_valid);
            end
            n_cmp++;
            if (n_done != 1 || done_cyc != 0 || n_err != 1 || err_cyc != 0) begin
                n_bad++;
                $display("FAIL err%0d_pulse got done n=%0d cyc=%0d err n=%0d cyc=%0d want 1 0 1 0",
                         k, n_done, done_cyc, n_err, err_cyc);
            end
        end
    endtask

    // start during RUN and during FIN must both be ignored.
    task automatic test_start_abuse();
        go(1'b0, 8'd0, 8'd6, 6'd1, 3'd3, 2'd1);
        capture(1'b0, 1'b0, 5, -1, 2);
        check_basic_seq("startrun");
        go(1'b0, 8'd0, 8'd6, 6'd1, 3'd3, 2'd1);
        capture(1'b0, 1'b0, 12, -1, 3);
        n_cmp++;
        if (done_cyc != 12 || post_busy != 0) begin
            n_bad++; $display("FAIL startfin got done cyc=%0d busy after=%0d want 12 0",
                              done_cyc, post_busy);
        end
    endtask

    task automatic test_reset_mid_row();
        logic [14:0] obs8;
        go(1'b0, 8'd0, 8'd6, 6'd1, 3'd3, 2'd1);
        capture(1'b0, 1'b0, -1, 4, 0);
        @(negedge clk);
        obs8 = {busy8, rd8.addr_valid, rd8.raddr, rd8.win_first, rd8.win_last,
                rd8.row_last, done8, err8};
        n_cmp++;
        if (obs8 !== 15'd0) begin
            n_bad++; $display("FAIL midrst outputs got %h want 0", obs8);
        end
        rst = 1'b0;
        go(1'b0, 8'd0, 8'd6, 6'd1, 3'd3, 2'd1);
        capture(1'b0, 1'b0, -1, -1, 2);
        check_basic_seq("afterrst");
    endtask

    initial begin
        rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
        base8 = 8'd0; base4 = 4'd0; row_len = 8'd0; rows = 6'd0;
        filt = 3'd0; stride = 2'd0;
        rd8.addr_ready = 1'b1; rd4.addr_ready = 1'b1;
        test_reset();
        test_basic();
        test_multi_back_to_back();
        test_wrap();
        test_backpressure();
        test_cfg_err();
        test_start_abuse();
        test_reset_mid_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
